avalon_ram_arbiter: RTL and testbench

Two-master Avalon-MM arbiter and wait-state controller in front of the shared RAM_8x8192_bus.
- Master 0 is the mips_cpu_bus port; master 1 is a loader/debug port.
- Grants one master at a time and drives the RAM strobes for a programmable number of cycles.
- Generates each master's waitrequest and registers read data, replacing ad-hoc bench-side waitrequest generation.

---
 rtl/avalon_arb_pkg.sv | 8 +
 rtl/arb_rr_picker.sv | 14 +
 rtl/avalon_ram_arbiter.sv | 71 +++++++
 tb/tb_avalon_ram_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg: shared state type and bus widths for the Avalon RAM arbiter
package avalon_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  localparam int N_MASTERS = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
endpackage

// File: rtl/arb_rr_picker.sv
// arb_rr_picker: two-master winner select, round-robin, or fixed priority when AVALON_ARB_FIXED_PRIO_EN is defined
module arb_rr_picker (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);
`ifdef AVALON_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  assign winner = ~req[0];
`else
  assign winner = &req ? ~last : req[1];
`endif
endmodule

// File: rtl/avalon_ram_arbiter.sv
// avalon_ram_arbiter: two-master Avalon-MM RAM arbiter with wait-state control; AVALON_ARB_FIXED_PRIO_EN selects fixed priority
module avalon_ram_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int READ_WAIT  = 3,
  parameter int WRITE_WAIT = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_MASTERS-1:0]               m_read,
  input  logic [N_MASTERS-1:0]               m_write,
  input  logic [N_MASTERS-1:0][ADDR_W-1:0]   m_address,
  input  logic [N_MASTERS-1:0][BE_W-1:0]     m_byteenable,
  input  logic [N_MASTERS-1:0][DATA_W-1:0]   m_writedata,
  output logic [N_MASTERS-1:0]               m_waitrequest,
  output logic [DATA_W-1:0]                  m_readdata,
  output logic                               s_read,
  output logic                               s_write,
  output logic [ADDR_W-1:0]                  s_address,
  output logic [BE_W-1:0]                    s_byteenable,
  output logic [DATA_W-1:0]                  s_writedata,
  input  logic [DATA_W-1:0]                  s_readdata
);
  localparam int MAX_WAIT = READ_WAIT > WRITE_WAIT ? READ_WAIT : WRITE_WAIT;
  localparam int CW = $clog2(MAX_WAIT) + 1;
  arb_state_t state;
  logic grant, last, is_write, winner;
  logic [CW-1:0] cnt, end_cnt;
  logic [N_MASTERS-1:0] req;
  assign req = m_read | m_write;
  assign end_cnt = is_write ? CW'(WRITE_WAIT - 1) : CW'(READ_WAIT - 1);
  assign s_read = state == ACCESS && !is_write;
  assign s_write = state == ACCESS && is_write;
  assign s_address = m_address[grant];
  assign s_byteenable = m_byteenable[grant];
  assign s_writedata = m_writedata[grant];
  assign m_waitrequest = state == DONE ? ~(N_MASTERS'(1) << grant) : '1;
  arb_rr_picker u_pick (
    .req(req),
    .last(last),
    .winner(winner)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      last <= 1'b1;
      is_write <= 1'b0;
      cnt <= '0;
      m_readdata <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= ACCESS;
          grant <= winner;
          last <= winner;
          is_write <= m_write[winner];
          cnt <= '0;
        end
        ACCESS: begin
          cnt <= cnt + CW'(1);
          if (cnt == end_cnt) begin
            state <= DONE;
            if (!is_write) m_readdata <= s_readdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_ram_arbiter.sv
// tb_avalon_ram_arbiter: randomized transaction-level check of the arbiter against a timeline and memory model
module tb_avalon_ram_arbiter;
  localparam int RW = 3;
  localparam int WW = 4;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic [1:0] m_read, m_write, wreq;
  logic [1:0][31:0] m_address, m_writedata;
  logic [1:0][3:0] m_byteenable;
  logic [31:0] rdata, s_address, s_writedata, s_readdata;
  logic [3:0] s_be;
  logic s_read, s_write;
  logic [1:0] b_read, b_write, b_wreq;
  logic [1:0][31:0] b_address, b_writedata;
  logic [1:0][3:0] b_byteenable;
  logic [31:0] b_rdata, b_sa, b_swd, b_srd;
  logic [3:0] b_sbe;
  logic b_sr, b_sw;
  logic [31:0] mem [256];
  logic [31:0] mem_b [256];
  logic [31:0] ref_mem [256];
  int total = 0, bad = 0, last_m = 1;

  avalon_ram_arbiter #(.READ_WAIT(RW), .WRITE_WAIT(WW)) u_dut (
    .clk(clk), .reset(reset), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_waitrequest(wreq), .m_readdata(rdata), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_byteenable(s_be), .s_writedata(s_writedata),
    .s_readdata(s_readdata)
  );
  avalon_ram_arbiter #(.READ_WAIT(1), .WRITE_WAIT(1)) u_fast (
    .clk(clk), .reset(reset), .m_read(b_read), .m_write(b_write),
    .m_address(b_address), .m_byteenable(b_byteenable), .m_writedata(b_writedata),
    .m_waitrequest(b_wreq), .m_readdata(b_rdata), .s_read(b_sr), .s_write(b_sw),
    .s_address(b_sa), .s_byteenable(b_sbe), .s_writedata(b_swd),
    .s_readdata(b_srd)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, d, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i+:8] = d[8*i+:8];
    return o;
  endfunction

  assign s_readdata = mem[s_address[9:2]];
  assign b_srd = mem_b[b_sa[9:2]];
  always @(posedge clk) if (s_write) mem[s_address[9:2]] <= merge(mem[s_address[9:2]], s_writedata, s_be);
  always @(posedge clk) if (b_sw) mem_b[b_sa[9:2]] <= merge(mem_b[b_sa[9:2]], b_swd, b_sbe);

  task automatic check(input string tag, input logic [31:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after an edge with the arbiter idle; cycle n counts edges from here.
  task automatic run_txn(input logic [1:0] rd, wt, input logic [31:0] a0, a1, d0, d1,
                         input logic [3:0] be0, be1);
    int ord[2], st[2], dn[2], nt, cur;
    logic [1:0] ew;
    logic er, ewr, act;
    m_address[0] = a0; m_address[1] = a1;
    m_writedata[0] = d0; m_writedata[1] = d1;
    m_byteenable[0] = be0; m_byteenable[1] = be1;
    m_read = rd; m_write = wt;
    nt = &(rd | wt) ? 2 : 1;
`ifdef AVALON_ARB_FIXED_PRIO_EN
    ord[0] = (rd[0] | wt[0]) ? 0 : 1;
`else
    ord[0] = &(rd | wt) ? 1 - last_m : ((rd[0] | wt[0]) ? 0 : 1);
`endif
    ord[1] = 1 - ord[0];
    st[0] = 1;
    dn[0] = 1 + (wt[ord[0]] ? WW : RW);
    st[1] = dn[0] + 2;
    dn[1] = st[1] + (wt[ord[1]] ? WW : RW);
    for (int n = 1; n <= dn[nt-1]; n++) begin
      @(posedge clk); #1;
      ew = 2'b11; er = 1'b0; ewr = 1'b0; act = 1'b0; cur = 0;
      for (int k = 0; k < nt; k++) begin
        if (n == dn[k]) ew[ord[k]] = 1'b0;
        if (n >= st[k] && n < dn[k]) begin
          act = 1'b1; cur = ord[k]; er = !wt[cur]; ewr = wt[cur];
        end
      end
      check("waitrequest", 32'(wreq), 32'(ew));
      check("s_read", 32'(s_read), 32'(er));
      check("s_write", 32'(s_write), 32'(ewr));
      if (act) begin
        check("s_address", s_address, m_address[cur]);
        if (ewr) begin
          check("s_writedata", s_writedata, m_writedata[cur]);
          check("s_byteenable", 32'(s_be), 32'(m_byteenable[cur]));
        end
      end
      for (int k = 0; k < nt; k++) if (n == dn[k]) begin
        cur = ord[k];
        if (wt[cur]) ref_mem[m_address[cur][9:2]] = merge(ref_mem[m_address[cur][9:2]], m_writedata[cur], m_byteenable[cur]);
        else check("m_readdata", rdata, ref_mem[m_address[cur][9:2]]);
        last_m = cur;
        m_read[cur] = 1'b0;
        m_write[cur] = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("idle_waitrequest", 32'(wreq), 32'h3);
    check("idle_strobes", 32'({s_read, s_write}), 32'h0);
  endtask

  task automatic rand_txn();
    logic [1:0] rd, wt;
    rd = 2'($urandom); wt = 2'($urandom);
    if ((rd | wt) == 2'b00) rd[$urandom_range(0, 1)] = 1'b1;
    run_txn(rd, wt, 32'($urandom_range(0, 7)) << 2, 32'($urandom_range(0, 7)) << 2,
            $urandom, $urandom, 4'($urandom), 4'($urandom));
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bdata;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i]; mem_b[i] = $urandom;
    end
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    reset = 1'b1; m_read = '0; m_write = '0; m_address = '0; m_writedata = '0; m_byteenable = '0;
    b_read = '0; b_write = '0; b_address = '0; b_writedata = '0; b_byteenable = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_waitrequest", 32'(wreq), 32'h3);
    check("reset_readdata", rdata, 32'h0);
    check("reset_strobes", 32'({s_read, s_write}), 32'h0);
    reset = 1'b0;
    run_txn(2'b11, 2'b00, 32'h4, 32'h8, 0, 0, 4'hf, 4'hf);
    run_txn(2'b11, 2'b00, 32'hc, 32'h10, 0, 0, 4'hf, 4'hf);
    run_txn(2'b01, 2'b00, 32'h10, 32'h0, 0, 0, 4'hf, 4'hf);
    run_txn(2'b00, 2'b10, 32'h0, 32'h20, 0, 32'h12345678, 4'hf, 4'b0011);
    run_txn(2'b01, 2'b00, 32'h20, 32'h0, 0, 0, 4'hf, 4'hf);
    run_txn(2'b01, 2'b01, 32'h18, 32'h0, 32'hA5A5_0F0F, 0, 4'hf, 4'hf);
    repeat (60) rand_txn();
    m_address[0] = 32'h1c; m_writedata[0] = 32'hCAFEF00D; m_byteenable[0] = 4'hf; m_write = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    check("midwrite_s_write", 32'(s_write), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; m_write = 2'b00;
    ref_mem[7] = 32'hCAFEF00D;
    last_m = 1;
    check("midreset_strobes", 32'({s_read, s_write}), 32'h0);
    check("midreset_waitrequest", 32'(wreq), 32'h3);
    check("midreset_readdata", rdata, 32'h0);
    @(posedge clk); #1;
    check("postreset_waitrequest", 32'(wreq), 32'h3);
    run_txn(2'b11, 2'b00, 32'h1c, 32'h10, 0, 0, 4'hf, 4'hf);
    repeat (15) rand_txn();
    bdata = $urandom;
    b_address[0] = 32'h8; b_writedata[0] = bdata; b_byteenable[0] = 4'hf; b_write = 2'b01;
    @(posedge clk); #1;
    check("fast_s_write", 32'(b_sw), 32'h1);
    check("fast_wait_c1", 32'(b_wreq), 32'h3);
    @(posedge clk); #1;
    check("fast_write_done", 32'(b_wreq), 32'h2);
    check("fast_write_strobe_off", 32'(b_sw), 32'h0);
    b_write = 2'b00;
    @(posedge clk); #1;
    b_address[1] = 32'h8; b_read = 2'b10;
    @(posedge clk); #1;
    check("fast_s_read", 32'(b_sr), 32'h1);
    @(posedge clk); #1;
    check("fast_read_done", 32'(b_wreq), 32'h1);
    check("fast_readdata", b_rdata, bdata);
    b_read = 2'b00;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
